lsu_sequencer: RTL

//  Multi-cycle load/store sequencer between decode/execute and the data-memory bus.
//  - Accepts one LOAD/STORE op at a time: func3, effective address, store data, rd.
//  - Drives a request/grant bus with word-aligned address, byte strobes and lane-replicated write data.
//  - Returns extracted, sign/zero-extended load data and an error flag (misaligned, illegal func3, timeout).

---
 rtl/lsu_sequencer.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/lsu_sequencer.sv
// lsu_sequencer: multi-cycle load/store sequencer between execute and a req/gnt data-memory bus.
// Ports: clk/rst (sync, active-high); req_* op from execute (valid/ready, we, func3, addr, wdata, rd);
// mem_* bus (req/gnt handshake, we, word addr, wstrb, lane-replicated wdata, rvalid/rdata);
// rsp_* one-cycle completion (rdata extended, rd, err); busy = not idle. All outputs registered.
// Optional: define LSU_TIMEOUT_EN to abort an op after TIMEOUT_CYC cycles stuck in ISSUE or WAIT.
module lsu_sequencer #(
  parameter int XLEN = 32
`ifdef LSU_TIMEOUT_EN
  , parameter int TIMEOUT_CYC = 15
`endif
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_we,
  input  logic [2:0]      req_func3,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  input  logic [4:0]      req_rd,
  output logic            mem_req,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [3:0]      mem_wstrb,
  output logic [XLEN-1:0] mem_wdata,
  input  logic            mem_gnt,
  input  logic            mem_rvalid,
  input  logic [XLEN-1:0] mem_rdata,
  output logic            rsp_valid,
  output logic [XLEN-1:0] rsp_rdata,
  output logic [4:0]      rsp_rd,
  output logic            rsp_err,
  output logic            busy
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  state_t state;
  logic we;
  logic [2:0] f3;
  logic [1:0] a_lo;
  logic [4:0] rd;
  logic bad;
  logic [3:0] strb;
  logic [XLEN-1:0] wd, sh, ld;
`ifdef LSU_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  logic [CW-1:0] cnt;
`endif
  always_comb begin
    bad = (req_func3[1:0] == 2'd1 && req_addr[0]) || (req_func3[1:0] == 2'd2 && |req_addr[1:0]) ||
          (req_we ? req_func3 > 3'd2 : (req_func3 == 3'd3 || req_func3[2:1] == 2'b11));
    strb = req_func3[1:0] == 2'd0 ? 4'b0001 << req_addr[1:0] :
           req_func3[1:0] == 2'd1 ? 4'b0011 << {req_addr[1], 1'b0} : 4'b1111;
    wd = req_func3[1:0] == 2'd0 ? {(XLEN/8){req_wdata[7:0]}} :
         req_func3[1:0] == 2'd1 ? {(XLEN/16){req_wdata[15:0]}} : req_wdata;
    // func3[2] selects zero-extension (LBU/LHU); func3[1] selects a full word.
    sh = mem_rdata >> {a_lo, 3'b000};
    ld = f3[1] ? sh :
         f3[0] ? {{(XLEN-16){~f3[2] & sh[15]}}, sh[15:0]} : {{(XLEN-8){~f3[2] & sh[7]}}, sh[7:0]};
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      req_ready <= 1'b1;
      mem_req <= 1'b0;
      mem_we <= 1'b0;
      mem_addr <= '0;
      mem_wstrb <= '0;
      mem_wdata <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_rd <= '0;
      rsp_err <= 1'b0;
      busy <= 1'b0;
      we <= 1'b0;
      f3 <= '0;
      a_lo <= '0;
      rd <= '0;
`ifdef LSU_TIMEOUT_EN
      cnt <= '0;
`endif
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          we <= req_we;
          f3 <= req_func3;
          a_lo <= req_addr[1:0];
          rd <= req_rd;
          req_ready <= 1'b0;
          busy <= 1'b1;
          if (bad) begin
            state <= RESP;
            rsp_valid <= 1'b1;
            rsp_err <= 1'b1;
            rsp_rd <= req_rd;
          end else begin
            state <= ISSUE;
            mem_req <= 1'b1;
            mem_we <= req_we;
            mem_addr <= {req_addr[XLEN-1:2], 2'b00};
            mem_wstrb <= req_we ? strb : 4'b0000;
            mem_wdata <= req_we ? wd : '0;
`ifdef LSU_TIMEOUT_EN
            cnt <= '0;
`endif
          end
        end
        ISSUE: if (mem_gnt) begin
          mem_req <= 1'b0;
          if (we || mem_rvalid) begin
            state <= RESP;
            rsp_valid <= 1'b1;
            rsp_rd <= rd;
            rsp_rdata <= we ? '0 : ld;
          end else begin
            state <= WAIT;
`ifdef LSU_TIMEOUT_EN
            cnt <= '0;
`endif
          end
        end
`ifdef LSU_TIMEOUT_EN
        else if (cnt == CW'(TIMEOUT_CYC - 1)) begin
          state <= RESP;
          mem_req <= 1'b0;
          rsp_valid <= 1'b1;
          rsp_err <= 1'b1;
          rsp_rd <= rd;
        end else cnt <= cnt + 1'b1;
`endif
        WAIT: if (mem_rvalid) begin
          state <= RESP;
          rsp_valid <= 1'b1;
          rsp_rd <= rd;
          rsp_rdata <= ld;
        end
`ifdef LSU_TIMEOUT_EN
        else if (cnt == CW'(TIMEOUT_CYC - 1)) begin
          state <= RESP;
          rsp_valid <= 1'b1;
          rsp_err <= 1'b1;
          rsp_rd <= rd;
        end else cnt <= cnt + 1'b1;
`endif
        default: begin
          state <= IDLE;
          rsp_valid <= 1'b0;
          rsp_err <= 1'b0;
          rsp_rdata <= '0;
          rsp_rd <= '0;
          req_ready <= 1'b1;
          busy <= 1'b0;
        end
      endcase
    end
  end
endmodule
